// File: rtl/npu_bus_master_if.sv
// Pipelined single-outstanding bus between the NPU burst master and its responder.
// Member names match the original flat port names so callers map one-to-one.
interface npu_bus_master_if #(
  parameter int unsigned DWidth = 32
);
  logic              sel_o;
  logic              trans_o;
  logic              write_o;
  logic [DWidth-1:0] addr_o;
  logic [DWidth-1:0] wdata_o;
  logic              ready_i;
  logic              resp_i;
  logic [DWidth-1:0] rdata_i;

  modport master (
    output sel_o, trans_o, write_o, addr_o, wdata_o,
    input  ready_i, resp_i, rdata_i
  );

  modport slave (
    input  sel_o, trans_o, write_o, addr_o, wdata_o,
    output ready_i, resp_i, rdata_i
  );
endinterface

// File: rtl/npu_bus_master.sv
// Burst master: turns one read/write command of 1..16 beats into pipelined
// address/data phases with wait-state, error-abort and address-wrap handling.
module npu_bus_master #(
  parameter int unsigned DWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [DWidth-1:0] cmd_addr_i,
  input  logic [3:0]        cmd_len_i,
  input  logic              wr_valid_i,
  input  logic [DWidth-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              rd_valid_o,
  output logic [DWidth-1:0] rd_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  npu_bus_master_if.master  bus
);

  localparam logic [DWidth-1:0] Step      = DWidth'(DWidth / 8);
  localparam logic [DWidth-1:0] AlignMask = ~DWidth'(3);

  typedef enum logic [1:0] {StIdle, StAddr, StDrain, StDone} state_e;

  state_e            state_q;
  logic              write_q;
  logic              pend_q;
  logic              pend_write_q;
  logic              err_q;
  logic [DWidth-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;

  logic in_addr;
  logic trans;
  logic accept;
  logic complete;
  logic err_now;
  logic last_beat;

  // ready_i both accepts the current address phase and completes the
  // outstanding data phase, which gives the one-deep pipeline.
  always_comb begin
    in_addr   = (state_q == StAddr);
    trans     = in_addr & (~write_q | wr_valid_i);
    accept    = trans & bus.ready_i;
    complete  = pend_q & bus.ready_i;
    err_now   = complete & bus.resp_i;
    last_beat = (cnt_q == len_q);
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign wr_ready_o  = accept & write_q;

  assign bus.sel_o   = in_addr;
  assign bus.trans_o = trans;
  assign bus.write_o = in_addr & write_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wr_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;

      // Read data is delivered only for clean beats issued before any error.
      if (complete && !pend_write_q && !bus.resp_i && !err_q) begin
        rd_valid_o <= 1'b1;
        rd_data_o  <= bus.rdata_i;
      end

      if (accept) begin
        addr_q       <= addr_q + Step;
        cnt_q        <= cnt_q + 4'd1;
        pend_q       <= 1'b1;
        pend_write_q <= write_q;
      end else if (complete) begin
        pend_q <= 1'b0;
      end

      if (err_now) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            write_q <= cmd_write_i;
            addr_q  <= cmd_addr_i & AlignMask;
            len_q   <= cmd_len_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          // A beat accepted alongside the error response still has to drain.
          if (err_now) begin
            if (accept) begin
              state_q <= StDrain;
            end else begin
              state_q <= StDone;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
            end
          end else if (accept && last_beat) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (complete) begin
            state_q <= StDone;
            done_o  <= 1'b1;
            err_o   <= err_q | bus.resp_i;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_bus_master.sv
// Directed per-cycle vector table for npu_bus_master, plus hand-written
// error-abort and mid-burst reset sequences.
module tb_npu_bus_master;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        busy;

  npu_bus_master_if #(.DWidth(32)) bus ();

  npu_bus_master #(.DWidth(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cv;
    logic        cw;
    logic [31:0] caddr;
    logic [3:0]  clen;
    logic        wv;
    logic [31:0] wdata;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        e_cr;
    logic        e_wrr;
    logic        e_sel;
    logic        e_trans;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_done;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 32'h0;
    cmd_len     = 4'd0;
    wr_valid    = 1'b0;
    wr_data     = 32'h0;
    bus.ready_i = 1'b1;
    bus.resp_i  = 1'b0;
    bus.rdata_i = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_trans;
    int n_rv;
    int n_done;
    int done_k;
    logic done_err;
    logic [31:0] last_rd;
    logic [31:0] last_taddr;

    drive_idle();
    bus.ready_i = 1'b0;

    // Read, len 0, unaligned address (low bits dropped)
    vecs.push_back('{H,L,32'h8000_0013,4'd0, L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h0,         L,32'h0,         L,L,L});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,H,H,L,32'h8000_0010, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'hDEAD_BEEF, L,L,L,L,L,32'h8000_0014, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,L,L,L,32'h8000_0014, H,32'hDEAD_BEEF, H,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h8000_0014, L,32'h0,         L,L,L});
    // Write, len 3, continuous write data
    vecs.push_back('{H,H,32'h0000_0100,4'd3, L,32'h0,  H,L,32'h0, H,L,L,L,L,32'h8000_0014, L,32'h0, L,L,L});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hA0, H,L,32'h0, L,H,H,H,H,32'h0000_0100, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hA1, H,L,32'h0, L,H,H,H,H,32'h0000_0104, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hA2, H,L,32'h0, L,H,H,H,H,32'h0000_0108, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hA3, H,L,32'h0, L,H,H,H,H,32'h0000_010C, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,L,L,L,32'h0000_0110, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,L,L,L,32'h0000_0110, L,32'h0, H,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, H,L,L,L,L,32'h0000_0110, L,32'h0, L,L,L});
    // Read, len 1, address wraps past the top of the address space
    vecs.push_back('{H,L,32'hFFFF_FFFC,4'd1, L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h0000_0110, L,32'h0,         L,L,L});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,H,H,L,32'hFFFF_FFFC, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h1111_1111, L,L,H,H,L,32'h0000_0000, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h2222_2222, L,L,L,L,L,32'h0000_0004, H,32'h1111_1111, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,L,L,L,32'h0000_0004, H,32'h2222_2222, H,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h0000_0004, L,32'h0,         L,L,L});
    // Read, len 1, two wait states in beat 0's data phase
    vecs.push_back('{H,L,32'h0000_0200,4'd1, L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h0000_0004, L,32'h0,         L,L,L});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,H,H,L,32'h0000_0200, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, L,L,32'h5555_5555, L,L,H,H,L,32'h0000_0204, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, L,L,32'h6666_6666, L,L,H,H,L,32'h0000_0204, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'hAAAA_0000, L,L,H,H,L,32'h0000_0204, L,32'h0,         L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'hBBBB_1111, L,L,L,L,L,32'h0000_0208, H,32'hAAAA_0000, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         L,L,L,L,L,32'h0000_0208, H,32'hBBBB_1111, H,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0, H,L,32'h0,         H,L,L,L,L,32'h0000_0208, L,32'h0,         L,L,L});
    // Write, len 2, three-cycle write-data gap before beat 1
    vecs.push_back('{H,H,32'h0000_0300,4'd2, L,32'h0,  H,L,32'h0, H,L,L,L,L,32'h0000_0208, L,32'h0, L,L,L});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hB0, H,L,32'h0, L,H,H,H,H,32'h0000_0300, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,H,L,H,32'h0000_0304, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,H,L,H,32'h0000_0304, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,H,L,H,32'h0000_0304, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hB1, H,L,32'h0, L,H,H,H,H,32'h0000_0304, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         H,32'hB2, H,L,32'h0, L,H,H,H,H,32'h0000_0308, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,L,L,L,32'h0000_030C, L,32'h0, L,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, L,L,L,L,L,32'h0000_030C, L,32'h0, H,L,H});
    vecs.push_back('{L,L,32'h0,4'd0,         L,32'h0,  H,L,32'h0, H,L,L,L,L,32'h0000_030C, L,32'h0, L,L,L});

    // Reset state
    #1 rst_ni = 1'b0;
    #2;
    chk_b("reset busy", busy, 1'b0);
    chk_b("reset sel", bus.sel_o, 1'b0);
    chk_b("reset trans", bus.trans_o, 1'b0);
    chk_b("reset done", done, 1'b0);
    chk_b("reset rd_valid", rd_valid, 1'b0);
    chk_w("reset addr", bus.addr_o, 32'h0);
    chk_w("reset rd_data", rd_data, 32'h0);
    chk_b("reset cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      cmd_valid   = v.cv;
      cmd_write   = v.cw;
      cmd_addr    = v.caddr;
      cmd_len     = v.clen;
      wr_valid    = v.wv;
      wr_data     = v.wdata;
      bus.ready_i = v.rdy;
      bus.resp_i  = v.resp;
      bus.rdata_i = v.rdata;
      #1;
      chk_b($sformatf("row%0d cmd_ready", i), cmd_ready, v.e_cr);
      chk_b($sformatf("row%0d wr_ready", i), wr_ready, v.e_wrr);
      chk_b($sformatf("row%0d sel", i), bus.sel_o, v.e_sel);
      chk_b($sformatf("row%0d trans", i), bus.trans_o, v.e_trans);
      chk_b($sformatf("row%0d write", i), bus.write_o, v.e_wr);
      chk_w($sformatf("row%0d addr", i), bus.addr_o, v.e_addr);
      chk_w($sformatf("row%0d wdata", i), bus.wdata_o, v.wdata);
      chk_b($sformatf("row%0d rd_valid", i), rd_valid, v.e_rv);
      if (v.e_rv) chk_w($sformatf("row%0d rd_data", i), rd_data, v.e_rd);
      chk_b($sformatf("row%0d done", i), done, v.e_done);
      if (v.e_done) chk_b($sformatf("row%0d err", i), err, v.e_err);
      chk_b($sformatf("row%0d busy", i), busy, v.e_busy);
    end

    // Read len 3 with an error response in beat 1's data phase
    @(negedge clk);
    drive_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0400;
    cmd_len   = 4'd3;
    n_trans = 0; n_rv = 0; n_done = 0; done_k = 0; done_err = 1'b0;
    last_rd = 32'h0; last_taddr = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      bus.resp_i  = (k == 3);
      bus.rdata_i = 32'hC000_0000 + 32'(k);
      #1;
      if (bus.trans_o) begin n_trans++; last_taddr = bus.addr_o; end
      if (rd_valid) begin n_rv++; last_rd = rd_data; end
      if (done) begin n_done++; done_k = k; done_err = err; end
    end
    chk_w("err beats issued", 32'(n_trans), 32'd3);
    chk_w("err last beat addr", last_taddr, 32'h0000_0408);
    chk_w("err rd_valid count", 32'(n_rv), 32'd1);
    chk_w("err beat0 data", last_rd, 32'hC000_0002);
    chk_w("err done count", 32'(n_done), 32'd1);
    chk_w("err done cycle", 32'(done_k), 32'd5);
    chk_b("err flag", done_err, 1'b1);

    // Reset asserted in the middle of a write burst
    @(negedge clk);
    drive_idle();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0500;
    cmd_len   = 4'd3;
    wr_valid  = 1'b1;
    wr_data   = 32'h0000_00E0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_b("pre-reset busy", busy, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    chk_b("midrst sel", bus.sel_o, 1'b0);
    chk_b("midrst trans", bus.trans_o, 1'b0);
    chk_b("midrst write", bus.write_o, 1'b0);
    chk_b("midrst wr_ready", wr_ready, 1'b0);
    chk_b("midrst busy", busy, 1'b0);
    chk_b("midrst rd_valid", rd_valid, 1'b0);
    chk_b("midrst done", done, 1'b0);
    chk_b("midrst err", err, 1'b0);
    chk_w("midrst addr", bus.addr_o, 32'h0);
    chk_w("midrst rd_data", rd_data, 32'h0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk_b($sformatf("postrst%0d done", k), done, 1'b0);
      chk_b($sformatf("postrst%0d busy", k), busy, 1'b0);
    end

    // Fresh read after release: latency C+1 address, C+3 data and done
    @(negedge clk);
    drive_idle();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0600;
    done_k = 0; last_rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      bus.rdata_i = 32'h6000_0000 + 32'(k);
      #1;
      if (k == 1) begin
        chk_w("fresh addr C+1", bus.addr_o, 32'h0000_0600);
        chk_b("fresh trans C+1", bus.trans_o, 1'b1);
      end
      if (done && done_k == 0) begin
        done_k = k;
        last_rd = rd_data;
        chk_b("fresh rd_valid with done", rd_valid, 1'b1);
        chk_b("fresh err", err, 1'b0);
      end
    end
    chk_w("fresh done cycle", 32'(done_k), 32'd3);
    chk_w("fresh rd_data", last_rd, 32'h6000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_bus_master.md
NPU_BUS_MASTER -- requirements
Module: npu_bus_master

Interface
REQ-001 SHALL have parameter DWidth, default 32, bus data/address width.
REQ-002 SHALL have port clk_i  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i  input  1  command request.
REQ-005 SHALL have port cmd_ready_o  output  1  command accepted when both high.
REQ-006 SHALL have port cmd_write_i  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port cmd_addr_i  input  DWidth  start byte address; bits [1:0] ignored.
REQ-008 SHALL have port cmd_len_i  input  4  beat count minus 1 (1..16 beats).
REQ-009 SHALL have port wr_valid_i / wr_data_i / wr_ready_o  in/in/out  1/DWidth/1  write-data stream.
REQ-010 SHALL have port rd_valid_o / rd_data_o  output  1/DWidth  read-data stream, no backpressure.
REQ-011 SHALL have port done_o / err_o  output  1/1  burst-complete pulse; err_o is valid with done_o.
REQ-012 SHALL have port busy_o  output  1  high whenever state is not StIdle.
REQ-013 SHALL have ports sel_o, trans_o (IDLE=0, NONSEQ=1), write_o  output  1 each  bus address-phase controls.
REQ-014 SHALL have ports addr_o, wdata_o  output  DWidth each  bus address and write data (same cycle).
REQ-015 SHALL have ports ready_i, resp_i (0 OKAY, 1 ERROR), rdata_i  input  1/1/DWidth  bus responder returns.

Function
REQ-016 SHALL implement states StIdle, StAddr, StDrain, StDone.
REQ-017 StIdle: cmd_ready_o=1; on cmd_valid_i latch write, {addr[DWidth-1:2],2'b00}, len; reset beat and error flags; go StAddr.
REQ-018 StAddr: sel_o=1, write_o=latched write, addr_o=current address; trans_o=NONSEQ for reads, for writes only while wr_valid_i=1, else IDLE.
REQ-019 A beat is accepted in any cycle with trans_o=NONSEQ and ready_i=1; wr_ready_o = accepted & write (combinational); wdata_o = wr_data_i.
REQ-020 On acceptance: address += DWidth/8, wrapping modulo 2^DWidth; beat counter += 1.
REQ-021 The cycle after an accepted beat is its data phase; it completes when ready_i=1; while ready_i=0 the master holds all outputs (wait state).
REQ-022 Address phase of beat n+1 SHALL overlap data phase of beat n (pipelined, one outstanding beat max).
REQ-023 Read data phase completion: register rdata_i into rd_data_o; rd_valid_o=1 for exactly the next cycle.
REQ-024 Last beat accepted -> StDrain, trans_o=IDLE, sel_o=0; data phase completes -> StDone.
REQ-025 resp_i=1 at a completing data phase: set error flag; issue no further address phases; drain any accepted beat, suppressing its rd_valid_o; -> StDone.
REQ-026 StDone: done_o=1, err_o=error flag, one cycle; -> StIdle next cycle; cmd_ready_o=0 in StDone.
REQ-027 Outside StAddr: sel_o=0, trans_o=IDLE, wr_ready_o=0.
REQ-028 Latency (zero wait, read len=0): cmd accepted cycle C, address phase C+1, data phase C+2, rd_valid_o and done_o at C+3.

Reset
REQ-029 rst_ni low SHALL immediately force StIdle, and set sel_o, trans_o, write_o, rd_valid_o, done_o, err_o, busy_o, wr_ready_o to 0 and addr_o, rd_data_o to 0.
REQ-030 Reset mid-burst SHALL drop in-flight beats without done_o; the first command after release starts a fresh burst.

Verification
REQ-031 Read, addr 0x8000_0010, len 0, ready_i=1 -> addr_o 0x8000_0010 at C+1; rd_data_o = rdata_i from C+2 at C+3 with done_o=1, err_o=0.
REQ-032 Write, len 3, wr_valid_i continuous -> 4 NONSEQ beats on consecutive cycles, addresses +0/+4/+8/+C, 4 wr_ready_o pulses, done_o at C+6.
REQ-033 Read, len 1, ready_i=0 for 2 cycles in beat 0's data phase -> addr_o/trans_o held; 2 rd_valid_o pulses in order; no duplicate beat.
REQ-034 Write, len 2, wr_valid_i gap of 3 cycles before beat 1 -> trans_o=IDLE during gap, sel_o stays 1, beats resume with correct address.
REQ-035 Read, len 3, resp_i=1 at beat 1 data phase -> beat 0 data delivered, beat 2 data suppressed, beat 3 never issued, done_o=1 with err_o=1.
REQ-036 Address 0xFFFF_FFFC, len 1 -> second beat address 0x0000_0000; rst_ni pulse mid-burst -> outputs 0 immediately, no done_o.
